// File: rtl/pc_redirect_reg.sv
// IF-stage program counter with flush redirect, stall hold and a one-entry
// buffer that keeps a branch resolved under stall until fetch is released.
module pc_redirect_reg #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INST_BYTES   = 4,
    parameter int                STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending_o,
    output logic               misalign_o
);

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    // Mask is all-zero when INST_BYTES is 1, so the flag folds to constant 0.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_vld_next;
    logic [ADDR_W-1:0] pend_addr_next;
    logic [ADDR_W-1:0] pc_next;
    logic              unused_stall;

    // Only bit 0 of the stall vector concerns the fetch stage.
    assign unused_stall = ^stall;

    always_comb begin
        pc_next        = pc;
        pend_vld_next  = pend_vld;
        pend_addr_next = pend_addr;
        if (!ce) begin
            pc_next       = RESET_VECTOR;
            pend_vld_next = 1'b0;
        end else if (flush_i) begin
            pc_next       = new_pc_i;
            pend_vld_next = 1'b0;
        end else if (stall[0]) begin
            if (branch_flag_i) begin
                pend_addr_next = branch_target_address_i;
                pend_vld_next  = 1'b1;
            end
        end else if (branch_flag_i) begin
            // A live branch supersedes anything captured during the stall.
            pc_next       = branch_target_address_i;
            pend_vld_next = 1'b0;
        end else if (pend_vld) begin
            pc_next       = pend_addr;
            pend_vld_next = 1'b0;
        end else begin
            pc_next = pc + PC_INC;
        end
    end

    // Fetch-address register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            ce         <= 1'b0;
            pc         <= RESET_VECTOR;
            pend_vld   <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            ce         <= 1'b1;
            pc         <= pc_next;
            pend_vld   <= pend_vld_next;
            misalign_o <= is_misaligned(pc_next);
        end
    end

    always_ff @(posedge clk) begin
        pend_addr <= pend_addr_next;
    end

    assign redirect_pending_o = pend_vld;

endmodule
